// File: rtl/vga_axi_rd_arb_if.sv
//------------------------------------------------------------------------------
// Module : vga_axi_rd_arb_if
// Brief  : Bundle of both requester ports and the memory-side AXI4-Lite read port.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_axi_rd_arb_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_ADDR_WIDTH-1:0] s0_araddr_i;
  logic [2:0]                s0_arprot_i;
  logic                      s0_arvalid_i;
  logic                      s0_arrdy_o;
  logic [AXI_DATA_WIDTH-1:0] s0_rdata_o;
  logic [1:0]                s0_rresp_o;
  logic                      s0_rvalid_o;
  logic                      s0_rrdy_i;

  logic [AXI_ADDR_WIDTH-1:0] s1_araddr_i;
  logic [2:0]                s1_arprot_i;
  logic                      s1_arvalid_i;
  logic                      s1_arrdy_o;
  logic [AXI_DATA_WIDTH-1:0] s1_rdata_o;
  logic [1:0]                s1_rresp_o;
  logic                      s1_rvalid_o;
  logic                      s1_rrdy_i;

  logic [AXI_ADDR_WIDTH-1:0] m_araddr_o;
  logic [2:0]                m_arprot_o;
  logic                      m_arvalid_o;
  logic                      m_arrdy_i;
  logic [AXI_DATA_WIDTH-1:0] m_rdata_i;
  logic [1:0]                m_rresp_i;
  logic                      m_rvalid_i;
  logic                      m_rrdy_o;

  // Arbiter-side view
  modport master (
    input  s0_araddr_i, s0_arprot_i, s0_arvalid_i, s0_rrdy_i,
    output s0_arrdy_o, s0_rdata_o, s0_rresp_o, s0_rvalid_o,
    input  s1_araddr_i, s1_arprot_i, s1_arvalid_i, s1_rrdy_i,
    output s1_arrdy_o, s1_rdata_o, s1_rresp_o, s1_rvalid_o,
    output m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
    input  m_arrdy_i, m_rdata_i, m_rresp_i, m_rvalid_i
  );

  // Environment view (requesters plus memory slave)
  modport slave (
    output s0_araddr_i, s0_arprot_i, s0_arvalid_i, s0_rrdy_i,
    input  s0_arrdy_o, s0_rdata_o, s0_rresp_o, s0_rvalid_o,
    output s1_araddr_i, s1_arprot_i, s1_arvalid_i, s1_rrdy_i,
    input  s1_arrdy_o, s1_rdata_o, s1_rresp_o, s1_rvalid_o,
    input  m_araddr_o, m_arprot_o, m_arvalid_o, m_rrdy_o,
    output m_arrdy_i, m_rdata_i, m_rresp_i, m_rvalid_i
  );
endinterface

`default_nettype wire

// File: rtl/vga_axi_rd_arb.sv
//------------------------------------------------------------------------------
// Module : vga_axi_rd_arb
// Brief  : Two-requester AXI4-Lite read arbiter, s0 priority with s1 anti-starvation.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_axi_rd_arb #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int STARVE_LIMIT   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  vga_axi_rd_arb_if.master  bus,
  output logic              grant_o,
  output logic              busy_o
);

  localparam int c_CW = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [2:0]                r_arprot;
  logic                      r_grant;
  logic [c_CW-1:0]           r_starve;

  logic w_req_any;
  logic w_starve_hit;
  logic w_pick1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rrdy_sel;
  logic w_m_rrdy;
  logic w_rvalid0;
  logic w_rvalid1;

  assign w_req_any    = bus.s0_arvalid_i | bus.s1_arvalid_i;
  assign w_starve_hit = (STARVE_LIMIT != 0) && (r_starve == c_LIMIT);
  assign w_pick1      = bus.s1_arvalid_i & (~bus.s0_arvalid_i | w_starve_hit);
  assign w_rrdy_sel   = r_grant ? bus.s1_rrdy_i : bus.s0_rrdy_i;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_m_rrdy    = 1'b0;
    w_rvalid0   = 1'b0;
    w_rvalid1   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_gnt0      = ~w_pick1;
          w_gnt1      = w_pick1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.m_arrdy_i) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_m_rrdy  = w_rrdy_sel;
        w_rvalid0 = bus.m_rvalid_i & ~r_grant;
        w_rvalid1 = bus.m_rvalid_i & r_grant;
        if (bus.m_rvalid_i && w_rrdy_sel) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_araddr <= '0;
      r_arprot <= '0;
      r_grant  <= 1'b0;
      r_starve <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_req_any) begin
        r_araddr <= w_pick1 ? bus.s1_araddr_i : bus.s0_araddr_i;
        r_arprot <= w_pick1 ? bus.s1_arprot_i : bus.s0_arprot_i;
        r_grant  <= w_pick1;
        // Only contested s0 wins count toward forcing s1
        if (w_pick1) begin
          r_starve <= '0;
        end else if (bus.s1_arvalid_i && r_starve != c_LIMIT) begin
          r_starve <= r_starve + c_CW'(1);
        end
      end
    end
  end

  // Grant pulse is masked while reset is held so no handshake leaks through
  assign bus.s0_arrdy_o  = w_gnt0 & rst_n;
  assign bus.s1_arrdy_o  = w_gnt1 & rst_n;
  assign bus.s0_rvalid_o = w_rvalid0;
  assign bus.s1_rvalid_o = w_rvalid1;
  assign bus.s0_rdata_o  = bus.m_rdata_i;
  assign bus.s1_rdata_o  = bus.m_rdata_i;
  assign bus.s0_rresp_o  = bus.m_rresp_i;
  assign bus.s1_rresp_o  = bus.m_rresp_i;
  assign bus.m_araddr_o  = r_araddr;
  assign bus.m_arprot_o  = r_arprot;
  assign bus.m_arvalid_o = (r_state == ST_ADDR);
  assign bus.m_rrdy_o    = w_m_rrdy;
  assign grant_o         = r_grant;
  assign busy_o          = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vga_axi_rd_arb.sv
//------------------------------------------------------------------------------
// Module : tb_vga_axi_rd_arb
// Brief  : Random requesters and memory against a transaction-level arbiter model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_axi_rd_arb;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_axi_rd_arb_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) a ();
  vga_axi_rd_arb_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) b ();
  logic grant_a, busy_a, grant_b, busy_b;

  vga_axi_rd_arb #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(a), .grant_o(grant_a), .busy_o(busy_a));

  // Strict-priority instance under permanent contention
  vga_axi_rd_arb #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .STARVE_LIMIT(0)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .bus(b), .grant_o(grant_b), .busy_o(busy_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] ad);
    return {ad ^ 32'hA5A5_5A5A, ~ad};
  endfunction

  typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } ar_t;
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } r_t;

  // Reference model: one outstanding transaction, phase 0 idle / 1 address / 2 data
  int  m_phase, m_grant, starve, done_cnt;
  ar_t ar_q[$];
  r_t  r_q[$];
  int  g_cnt0, g_cnt1, arhs_cnt, rhs_cnt;
  logic [AW-1:0] ev_addr;
  logic [1:0]    mem_resp;
  logic          mon_en = 1'b0;

  logic          pend [2];
  logic [AW-1:0] req_addr [2];
  logic [2:0]    req_prot [2];

  int s0_strict, s1_strict;

  initial begin
    m_phase = 0; m_grant = 0; starve = 0; done_cnt = 0;
    g_cnt0 = 0; g_cnt1 = 0; arhs_cnt = 0; rhs_cnt = 0;
    ev_addr = '0; mem_resp = 2'b00;
  end

  always @(negedge clk) begin : mon
    logic v0, v1, ew, any, rsel;
    logic [DW-1:0] rd;
    logic [1:0]    rr;
    if (!rst_n) begin
      m_phase = 0; m_grant = 0; starve = 0;
      ar_q.delete(); r_q.delete();
    end else if (mon_en) begin
      v0   = a.s0_arvalid_i;
      v1   = a.s1_arvalid_i;
      any  = (m_phase == 0) && (v0 || v1);
      ew   = (v0 && v1) ? (LIM != 0 && starve >= LIM) : v1;
      rsel = (m_grant != 0) ? a.s1_rrdy_i : a.s0_rrdy_i;
      chk("busy", busy_a, m_phase != 0);
      chk("grant", grant_a, m_grant != 0);
      chk("m_arvalid", a.m_arvalid_o, m_phase == 1);
      chk("s0_arrdy", a.s0_arrdy_o, any && !ew);
      chk("s1_arrdy", a.s1_arrdy_o, any && ew);
      chk("m_rrdy", a.m_rrdy_o, m_phase == 2 && rsel);
      chk("s0_rvalid", a.s0_rvalid_o, m_phase == 2 && m_grant == 0 && a.m_rvalid_i);
      chk("s1_rvalid", a.s1_rvalid_o, m_phase == 2 && m_grant == 1 && a.m_rvalid_i);
      if (m_phase == 1 && ar_q.size() > 0)
        chk("m_araddr_prot", {a.m_araddr_o, a.m_arprot_o}, {ar_q[0].addr, ar_q[0].prot});
      if (any) begin
        ar_q.push_back('{addr: req_addr[ew], prot: req_prot[ew]});
        if (ew) starve = 0;
        else if (v1 && starve < LIM) starve++;
        m_grant = ew ? 1 : 0;
        if (ew) g_cnt1++; else g_cnt0++;
        m_phase = 1;
      end else if (m_phase == 1 && a.m_arrdy_i) begin
        mem_resp = 2'($urandom_range(3));
        ev_addr  = a.m_araddr_o;
        if (ar_q.size() > 0) begin
          r_q.push_back('{data: mem_word(ar_q[0].addr), resp: mem_resp});
          void'(ar_q.pop_front());
        end
        arhs_cnt++;
        m_phase = 2;
      end else if (m_phase == 2 && a.m_rvalid_i && rsel) begin
        rd = (m_grant != 0) ? a.s1_rdata_o : a.s0_rdata_o;
        rr = (m_grant != 0) ? a.s1_rresp_o : a.s0_rresp_o;
        if (r_q.size() > 0) begin
          chk("rdata", rd, r_q[0].data);
          chk("rresp", rr, r_q[0].resp);
          void'(r_q.pop_front());
        end else begin
          chk("r_unexpected", 1'b1, 1'b0);
        end
        rhs_cnt++;
        done_cnt++;
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b.s0_arrdy_o) s0_strict++;
      if (b.s1_arrdy_o) s1_strict++;
    end
  end

  int seen_g0 = 0, seen_g1 = 0, seen_ar = 0, seen_r = 0;
  int mem_cnt = 0;
  logic mem_wait = 1'b0;
  logic [AW-1:0] mem_addr;

  task automatic drive_reqs();
    a.s0_arvalid_i = pend[0]; a.s0_araddr_i = req_addr[0]; a.s0_arprot_i = req_prot[0];
    a.s1_arvalid_i = pend[1]; a.s1_araddr_i = req_addr[1]; a.s1_arprot_i = req_prot[1];
  endtask

  task automatic run_cycle();
    @(posedge clk); #1;
    if (g_cnt0 != seen_g0) begin pend[0] = 1'b0; seen_g0 = g_cnt0; end
    if (g_cnt1 != seen_g1) begin pend[1] = 1'b0; seen_g1 = g_cnt1; end
    for (int k = 0; k < 2; k++) begin
      if (!pend[k] && $urandom_range(3) != 0) begin
        pend[k]     = 1'b1;
        req_addr[k] = $urandom & 32'hFFFF_FFFC;
        req_prot[k] = 3'($urandom_range(7));
      end
    end
    drive_reqs();
    a.s0_rrdy_i = ($urandom_range(9) < 7);
    a.s1_rrdy_i = ($urandom_range(9) < 7);
    a.m_arrdy_i = ($urandom_range(9) < 6);
    if (rhs_cnt != seen_r) begin a.m_rvalid_i = 1'b0; seen_r = rhs_cnt; end
    if (arhs_cnt != seen_ar) begin
      mem_wait = 1'b1; mem_cnt = $urandom_range(3); mem_addr = ev_addr; seen_ar = arhs_cnt;
    end
    if (mem_wait) begin
      if (mem_cnt == 0) begin
        a.m_rvalid_i = 1'b1; a.m_rdata_i = mem_word(mem_addr); a.m_rresp_i = mem_resp;
        mem_wait = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (!a.m_rvalid_i) begin
      a.m_rdata_i = {$urandom, $urandom};
      a.m_rresp_i = 2'($urandom_range(3));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s0_arrdy"}, a.s0_arrdy_o, 1'b0);
    chk({tag, "_s1_arrdy"}, a.s1_arrdy_o, 1'b0);
    chk({tag, "_s0_rvalid"}, a.s0_rvalid_o, 1'b0);
    chk({tag, "_s1_rvalid"}, a.s1_rvalid_o, 1'b0);
    chk({tag, "_m_arvalid"}, a.m_arvalid_o, 1'b0);
    chk({tag, "_m_rrdy"}, a.m_rrdy_o, 1'b0);
    chk({tag, "_busy"}, busy_a, 1'b0);
    chk({tag, "_grant"}, grant_a, 1'b0);
    chk({tag, "_m_araddr"}, a.m_araddr_o, '0);
    chk({tag, "_m_arprot"}, a.m_arprot_o, 3'b000);
  endtask

  initial begin
    int n;
    s0_strict = 0; s1_strict = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    req_addr[0] = '0; req_addr[1] = '0; req_prot[0] = '0; req_prot[1] = '0;
    rst_n = 1'b0;
    drive_reqs();
    a.s0_arvalid_i = 1'b1; a.s1_arvalid_i = 1'b1;
    a.s0_rrdy_i = 1'b1; a.s1_rrdy_i = 1'b1;
    a.m_arrdy_i = 1'b1; a.m_rvalid_i = 1'b1; a.m_rdata_i = '0; a.m_rresp_i = 2'b00;
    b.s0_arvalid_i = 1'b1; b.s1_arvalid_i = 1'b1;
    b.s0_araddr_i = 32'h100; b.s1_araddr_i = 32'h200;
    b.s0_arprot_i = 3'b000; b.s1_arprot_i = 3'b001;
    b.s0_rrdy_i = 1'b1; b.s1_rrdy_i = 1'b1;
    b.m_arrdy_i = 1'b1; b.m_rvalid_i = 1'b1; b.m_rdata_i = 64'hDEAD; b.m_rresp_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    a.s0_arvalid_i = 1'b0; a.s1_arvalid_i = 1'b0; a.m_rvalid_i = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (1500) run_cycle();

    // Abandon a transaction mid-data with reset, then keep going
    n = 0;
    while (!a.m_rvalid_i && n < 300) begin run_cycle(); n++; end
    chk("reach_data_phase", a.m_rvalid_i, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    a.m_rvalid_i = 1'b0; mem_wait = 1'b0;
    seen_g0 = g_cnt0; seen_g1 = g_cnt1; seen_ar = arhs_cnt; seen_r = rhs_cnt;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("held");
    rst_n = 1'b1;
    n = done_cnt;
    repeat (800) run_cycle();
    chk("post_reset_progress", (done_cnt - n) > 20, 1'b1);
    chk("total_txns", done_cnt > 100, 1'b1);
    chk("strict_s1_grants", s1_strict, 0);
    chk("strict_s0_grants_20", s0_strict >= 20, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
